// File: rtl/sdram_pkg.sv
// sdram_pkg: shared command encodings and writer state type
// used by the SDRAM burst writer and its address generator
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACT,
    WR,
    PRE
  } wr_state_t;

endpackage

// File: rtl/sdram_burst_writer_if.sv
// sdram_burst_writer_if: job, arbiter, source and SDRAM bus
// signals of the burst writer; master is the writer side
interface sdram_burst_writer_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int LEN_W  = 10
);

  logic                          wr_start;
  logic [BANK_W+ROW_W+COL_W-1:0] wr_base_addr;
  logic [LEN_W-1:0]              wr_len;
  logic                          wr_busy;
  logic                          write_req;
  logic                          write_en;
  logic                          ref_req;
  logic                          write_end_flag;
  logic [DATA_W-1:0]             wr_data_in;
  logic                          wr_data_ack;
  logic [3:0]                    wr_cmd;
  logic [ROW_W-1:0]              wr_addr;
  logic [BANK_W-1:0]             wr_bank_addr;
  logic [DATA_W-1:0]             wr_dq;
  logic                          wr_dq_oe;

  modport master (
    input  wr_start, wr_base_addr, wr_len,
    input  write_en, ref_req, wr_data_in,
    output wr_busy, write_req, write_end_flag,
    output wr_data_ack, wr_cmd, wr_addr,
    output wr_bank_addr, wr_dq, wr_dq_oe
  );

  modport slave (
    output wr_start, wr_base_addr, wr_len,
    output write_en, ref_req, wr_data_in,
    input  wr_busy, write_req, write_end_flag,
    input  wr_data_ack, wr_cmd, wr_addr,
    input  wr_bank_addr, wr_dq, wr_dq_oe
  );

endinterface

// File: rtl/sdram_burst_writer_addr_gen.sv
// sdram_wr_addr_gen: linear {bank,row,col} counter plus burst count;
// flags describe what the pending burst advance will produce
module sdram_wr_addr_gen
  import sdram_pkg::*;
#(
  parameter int ROW_W     = 12,
  parameter int COL_W     = 9,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 10
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          load,
  input  logic [BANK_W+ROW_W+COL_W-1:0] base,
  input  logic [LEN_W-1:0]              len,
  input  logic                          adv,
  output logic [BANK_W+ROW_W+COL_W-1:0] lin,
  output logic                          row_end,
  output logic                          rem_zero
);

  localparam int AW = BANK_W + ROW_W + COL_W;

  logic [LEN_W-1:0] rem;

  // col carry ripples into row, row carry into bank, bank wraps
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      lin <= '0;
      rem <= '0;
    end else if (load) begin
      lin <= base;
      rem <= len;
    end else if (adv) begin
      lin <= lin + AW'(BURST_LEN);
      rem <= rem - LEN_W'(1);
    end
  end

  assign row_end  = &(lin[COL_W-1:0] | COL_W'(BURST_LEN - 1));
  assign rem_zero = (rem == LEN_W'(1));

endmodule

// File: rtl/sdram_burst_writer.sv
// sdram_burst_writer: ACT/WRITE/PRE burst write engine with refresh resume
// define SDRAM_WR_TEST_PATTERN_EN to drive an address pattern on DQ
module sdram_burst_writer
  import sdram_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 12,
  parameter int COL_W     = 9,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 10,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  sdram_burst_writer_if.master bus
);

  localparam int AW    = BANK_W + ROW_W + COL_W;
  localparam int BL1   = BURST_LEN - 1;
  localparam int TMX   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CMAX  = (TMX > BL1) ? TMX : BL1;
  localparam int CNT_W = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] RCD_END  = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] RP_END   = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] BEAT_END = CNT_W'(BL1);
  localparam logic [ROW_W-1:0] A10_ONE  = ROW_W'(1) << A10_BIT;

  wr_state_t         state;
  wr_state_t         exit_st;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     lin;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_nxt;
  logic              row_end;
  logic              rem_zero;
  logic              load;
  logic              last_beat;
  logic              cont;
  logic [DATA_W-1:0] src;

  assign {bank, row, col} = lin;
  assign col_nxt   = col + COL_W'(BURST_LEN);
  assign load      = (state == IDLE) && bus.wr_start &&
                     (bus.wr_len != '0);
  assign last_beat = (state == WR) && (cnt == BEAT_END);
  assign cont      = !rem_zero && !bus.ref_req && !row_end;

  // ack leads each beat by one cycle: last ACT cycle, then
  // every WR cycle except a final beat that does not chain
  assign bus.wr_data_ack =
    ((state == ACT) && (cnt == RCD_END)) ||
    ((state == WR) && ((cnt != BEAT_END) || cont));

  sdram_wr_addr_gen #(
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .BANK_W    (BANK_W),
    .BURST_LEN (BURST_LEN),
    .LEN_W     (LEN_W)
  ) u_addr_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (load),
    .base     (bus.wr_base_addr),
    .len      (bus.wr_len),
    .adv      (last_beat),
    .lin      (lin),
    .row_end  (row_end),
    .rem_zero (rem_zero)
  );

  // main FSM; command/address registered on the state edge
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state              <= IDLE;
      exit_st            <= IDLE;
      cnt                <= '0;
      bus.wr_cmd         <= CMD_NOP;
      bus.wr_addr        <= '0;
      bus.wr_bank_addr   <= '0;
      bus.write_req      <= 1'b0;
      bus.write_end_flag <= 1'b0;
      bus.wr_busy        <= 1'b0;
    end else begin
      bus.wr_cmd         <= CMD_NOP;
      bus.write_end_flag <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            state         <= REQ;
            bus.write_req <= 1'b1;
            bus.wr_busy   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.write_en) begin
            state            <= ACT;
            cnt              <= '0;
            bus.write_req    <= 1'b0;
            bus.wr_cmd       <= CMD_ACT;
            bus.wr_addr      <= row;
            bus.wr_bank_addr <= bank;
          end
        end
        ACT: begin
          if (cnt == RCD_END) begin
            state            <= WR;
            cnt              <= '0;
            bus.wr_cmd       <= CMD_WR;
            bus.wr_addr      <= ROW_W'(col);
            bus.wr_bank_addr <= bank;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR: begin
          if (cnt == BEAT_END) begin
            cnt <= '0;
            if (cont) begin
              bus.wr_cmd  <= CMD_WR;
              bus.wr_addr <= ROW_W'(col_nxt);
            end else begin
              state       <= PRE;
              bus.wr_cmd  <= CMD_PRE;
              bus.wr_addr <= A10_ONE;
              exit_st     <= rem_zero    ? IDLE :
                             bus.ref_req ? REQ  : ACT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRE: begin
          if (cnt == RP_END) begin
            cnt   <= '0;
            state <= exit_st;
            unique case (exit_st)
              IDLE: begin
                bus.wr_busy        <= 1'b0;
                bus.write_end_flag <= 1'b1;
              end
              REQ: bus.write_req <= 1'b1;
              default: begin
                bus.wr_cmd       <= CMD_ACT;
                bus.wr_addr      <= row;
                bus.wr_bank_addr <= bank;
              end
            endcase
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_WR_TEST_PATTERN_EN
  logic [AW-1:0] pat;
  logic          unused_data;
  assign pat = lin + ((state == WR) ?
                      (AW'(cnt) + AW'(1)) : AW'(0));
  assign src = DATA_W'(pat);
  assign unused_data = ^bus.wr_data_in;
`else
  assign src = bus.wr_data_in;
`endif

  // DQ follows ack by one cycle, aligned with the command stream
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      bus.wr_dq    <= '0;
      bus.wr_dq_oe <= 1'b0;
    end else begin
      bus.wr_dq_oe <= bus.wr_data_ack;
      if (bus.wr_data_ack) begin
        bus.wr_dq <= src;
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb_sdram_burst_writer: table-driven job checks plus
// hand sequences for len=0, restart and mid-burst reset
module tb_sdram_burst_writer;
  import sdram_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   n_cmp;
  int   n_bad;

  always #5 sys_clk = ~sys_clk;

  sdram_burst_writer_if bus ();

  sdram_burst_writer dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct {
    logic [22:0]      base;
    logic [9:0]       len;
    int               dly;
    bit               refm;
    bit               dbl;
    int               n_wr;
    logic [3:0][22:0] wr;
    int               n_act;
    logic [1:0][13:0] act;
    int               n_req;
  } vec_t;

  vec_t vt [6];

  function automatic logic [22:0] a3(input int b, input int r,
                                     input int c);
    return {2'(b), 12'(r), 9'(c)};
  endfunction

  function automatic logic [13:0] a2(input int b, input int r);
    return {2'(b), 12'(r)};
  endfunction

  function automatic vec_t mkv(
    input logic [22:0] base, input int len, input int dly,
    input bit refm, input bit dbl, input int n_wr,
    input logic [22:0] w0, input logic [22:0] w1,
    input logic [22:0] w2, input logic [22:0] w3,
    input int n_act, input logic [13:0] c0,
    input logic [13:0] c1, input int n_req);
    vec_t v;
    v.base   = base;
    v.len    = 10'(len);
    v.dly    = dly;
    v.refm   = refm;
    v.dbl    = dbl;
    v.n_wr   = n_wr;
    v.wr[0]  = w0;
    v.wr[1]  = w1;
    v.wr[2]  = w2;
    v.wr[3]  = w3;
    v.n_act  = n_act;
    v.act[0] = c0;
    v.act[1] = c1;
    v.n_req  = n_req;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_cmd"}, 32'(bus.wr_cmd), 32'(CMD_NOP));
    chk({nm, "_addr"}, 32'(bus.wr_addr), 0);
    chk({nm, "_ba"}, 32'(bus.wr_bank_addr), 0);
    chk({nm, "_dq"}, 32'(bus.wr_dq), 0);
    chk({nm, "_oe"}, 32'(bus.wr_dq_oe), 0);
    chk({nm, "_req"}, 32'(bus.write_req), 0);
    chk({nm, "_end"}, 32'(bus.write_end_flag), 0);
    chk({nm, "_ack"}, 32'(bus.wr_data_ack), 0);
    chk({nm, "_busy"}, 32'(bus.wr_busy), 0);
  endtask

  task automatic run_job(input vec_t v);
    logic [22:0] wl [$];
    logic [13:0] al [$];
    logic [11:0] cur_row;
    logic [15:0] p_dat;
    logic        p_ack;
    logic        p_req;
    int cyc, wait_c, n_ack, n_oe, n_req, n_pre;
    int beat, t_act, t_pre;
    bit done, new_act;
    cur_row = '0;
    p_dat   = '0;
    p_ack   = 1'b0;
    p_req   = 1'b0;
    cyc     = 0;
    wait_c  = 0;
    n_ack   = 0;
    n_oe    = 0;
    n_req   = 0;
    n_pre   = 0;
    beat    = 0;
    t_act   = 0;
    t_pre   = 0;
    done    = 1'b0;
    new_act = 1'b0;
    @(negedge sys_clk);
    bus.wr_start     = 1'b1;
    bus.wr_base_addr = v.base;
    bus.wr_len       = v.len;
    while (!done && cyc < 400) begin
      @(negedge sys_clk);
      cyc++;
      bus.wr_start = v.dbl && (cyc == 8);
      if (v.dbl && cyc == 8) begin
        bus.wr_base_addr = a3(2, 9, 0);
        bus.wr_len       = 10'd7;
      end
      chk("dq_oe", 32'(bus.wr_dq_oe), 32'(p_ack));
      if (p_ack) chk("dq", 32'(bus.wr_dq), 32'(p_dat));
      chk("busy", 32'(bus.wr_busy), 32'(!bus.write_end_flag));
      if (bus.write_req && !p_req) n_req++;
      p_req = bus.write_req;
      if (bus.wr_cmd == CMD_ACT) begin
        al.push_back({bus.wr_bank_addr, bus.wr_addr});
        cur_row = bus.wr_addr;
        t_act   = cyc;
        new_act = 1'b1;
      end
      if (bus.wr_cmd == CMD_WR) begin
        if (new_act) chk("rcd_gap", cyc - t_act, 4);
        else chk("burst_gap", beat, 4);
        new_act = 1'b0;
        beat    = 0;
        chk("wr_a10", 32'(bus.wr_addr[10]), 0);
        wl.push_back({bus.wr_bank_addr, cur_row,
                      bus.wr_addr[8:0]});
      end
      if (bus.wr_cmd == CMD_PRE) begin
        chk("pre_beats", beat, 4);
        chk("pre_a10", 32'(bus.wr_addr[10]), 1);
        n_pre++;
        t_pre = cyc;
        beat  = 0;
      end
      if (bus.wr_dq_oe) begin
        n_oe++;
        beat++;
      end
      if (bus.write_end_flag) begin
        done = 1'b1;
        chk("rp_gap", cyc - t_pre, 4);
      end
      if (bus.write_req) begin
        bus.write_en = (wait_c == v.dly);
        wait_c++;
      end else begin
        bus.write_en = 1'b0;
        wait_c = 0;
      end
      bus.ref_req    = v.refm && (wl.size() > 0) && (n_pre == 0);
      bus.wr_data_in = 16'($urandom);
      #1;
      if (bus.wr_data_ack) n_ack++;
      p_ack = bus.wr_data_ack;
      p_dat = bus.wr_data_in;
    end
    chk("job_done", 32'(done), 1);
    bus.write_en = 1'b0;
    bus.ref_req  = 1'b0;
    bus.wr_start = 1'b0;
    chk("n_wr", wl.size(), v.n_wr);
    for (int i = 0; i < v.n_wr && i < wl.size(); i++)
      chk("wr_addr", 32'(wl[i]), 32'(v.wr[i]));
    chk("n_act", al.size(), v.n_act);
    for (int i = 0; i < v.n_act && i < al.size(); i++)
      chk("act_addr", 32'(al[i]), 32'(v.act[i]));
    chk("n_req", n_req, v.n_req);
    chk("n_ack", n_ack, 32'(4 * v.len));
    chk("n_oe", n_oe, 32'(4 * v.len));
    @(negedge sys_clk);
    chk("end_pulse", 32'(bus.write_end_flag), 0);
    chk("idle_busy", 32'(bus.wr_busy), 0);
    chk("idle_req", 32'(bus.write_req), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    bus.wr_start     = 1'b0;
    bus.wr_base_addr = '0;
    bus.wr_len       = '0;
    bus.write_en     = 1'b0;
    bus.ref_req      = 1'b0;
    bus.wr_data_in   = '0;

    vt[0] = mkv(a3(0, 0, 0), 2, 0, 0, 0,
                2, a3(0, 0, 0), a3(0, 0, 4), '0, '0,
                1, a2(0, 0), '0, 1);
    vt[1] = mkv(a3(0, 0, 504), 3, 0, 0, 0,
                3, a3(0, 0, 504), a3(0, 0, 508), a3(0, 1, 0), '0,
                2, a2(0, 0), a2(0, 1), 1);
    vt[2] = mkv(a3(0, 0, 0), 4, 10, 1, 0,
                4, a3(0, 0, 0), a3(0, 0, 4), a3(0, 0, 8),
                a3(0, 0, 12),
                2, a2(0, 0), a2(0, 0), 2);
    vt[3] = mkv(a3(1, 4095, 508), 2, 3, 0, 0,
                2, a3(1, 4095, 508), a3(2, 0, 0), '0, '0,
                2, a2(1, 4095), a2(2, 0), 1);
    vt[4] = mkv(a3(3, 4095, 508), 2, 1, 0, 0,
                2, a3(3, 4095, 508), a3(0, 0, 0), '0, '0,
                2, a2(3, 4095), a2(0, 0), 1);
    vt[5] = mkv(a3(0, 7, 16), 1, 0, 0, 1,
                1, a3(0, 7, 16), '0, '0, '0,
                1, a2(0, 7), '0, 1);

    repeat (3) @(negedge sys_clk);
    chk_reset("rst");
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_reset("post_rst");

    for (int i = 0; i < 6; i++) run_job(vt[i]);

    @(negedge sys_clk);
    bus.wr_start     = 1'b1;
    bus.wr_len       = 10'd0;
    bus.wr_base_addr = a3(1, 2, 8);
    @(negedge sys_clk);
    bus.wr_start = 1'b0;
    repeat (8) begin
      @(negedge sys_clk);
      chk("len0_req", 32'(bus.write_req), 0);
      chk("len0_busy", 32'(bus.wr_busy), 0);
    end

    bus.wr_start     = 1'b1;
    bus.wr_len       = 10'd4;
    bus.wr_base_addr = a3(0, 3, 0);
    bus.write_en     = 1'b1;
    @(negedge sys_clk);
    bus.wr_start = 1'b0;
    for (int k = 0; k < 20 && bus.wr_cmd != CMD_WR; k++)
      @(negedge sys_clk);
    chk("reach_wr", 32'(bus.wr_cmd), 32'(CMD_WR));
    #2 sys_rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    bus.write_en = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_idle_busy", 32'(bus.wr_busy), 0);
    chk("rst_idle_cmd", 32'(bus.wr_cmd), 32'(CMD_NOP));
    run_job(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
